// File: rtl/spi_config_master.sv
// ============================================================================
// Module      : spi_config_master
// Description : SPI Mode-0 initiator that streams frames of bytes under one
//               SS-low window, MSB first, and captures MISO readback.
//               Optional macro SPI_MOSI_PAD_EN appends 2 zero SCLK pulses
//               after the last byte of every frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_config_master #(
    parameter int LEN_W = 9,
    parameter int DIV_W = 8
) (
    input  logic             system_clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_bytes,
    input  logic [DIV_W-1:0] sclk_div,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             SCLK,
    output logic             MOSI,
    output logic             SS,
    input  logic             MISO
);

`ifdef SPI_MOSI_PAD_EN
    localparam logic c_PAD_EN = 1'b1;
`else
    localparam logic c_PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_TAIL     = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [DIV_W-1:0] r_timer,    w_timer_nxt;
    logic [DIV_W-1:0] r_div,      w_div_nxt;
    logic [LEN_W-1:0] r_remain,   w_remain_nxt;
    logic [2:0]       r_bit,      w_bit_nxt;
    logic [7:0]       r_tx_sh,    w_tx_sh_nxt;
    logic [7:0]       r_rx_sh,    w_rx_sh_nxt;
    logic             r_pad,      w_pad_nxt;
    logic [7:0]       r_rx_data,  w_rx_data_nxt;
    logic             r_rx_valid, w_rx_valid_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_sclk,     w_sclk_nxt;
    logic             r_ss,       w_ss_nxt;
    logic             w_phase_end;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_div      <= '0;
            r_remain   <= '0;
            r_bit      <= 3'd0;
            r_tx_sh    <= 8'h00;
            r_rx_sh    <= 8'h00;
            r_pad      <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sclk     <= 1'b0;
            r_ss       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_div      <= w_div_nxt;
            r_remain   <= w_remain_nxt;
            r_bit      <= w_bit_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_pad      <= w_pad_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_sclk     <= w_sclk_nxt;
            r_ss       <= w_ss_nxt;
        end
    end

    assign w_phase_end = (r_timer == r_div);

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = w_phase_end ? '0 : r_timer + DIV_W'(1);
        w_div_nxt      = r_div;
        w_remain_nxt   = r_remain;
        w_bit_nxt      = r_bit;
        w_tx_sh_nxt    = r_tx_sh;
        w_rx_sh_nxt    = r_rx_sh;
        w_pad_nxt      = r_pad;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_sclk_nxt     = r_sclk;
        w_ss_nxt       = r_ss;

        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (start && (frame_bytes != '0)) begin
                    w_div_nxt    = sclk_div;
                    w_remain_nxt = frame_bytes;
                    w_busy_nxt   = 1'b1;
                    w_ss_nxt     = 1'b0;
                    w_state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                w_timer_nxt = '0;
                if (tx_valid) begin
                    w_tx_sh_nxt = tx_data;
                    w_bit_nxt   = 3'd0;
                    w_pad_nxt   = 1'b0;
                    w_state_nxt = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (w_phase_end) begin
                    w_sclk_nxt = 1'b1;
                    if (!r_pad) begin
                        w_rx_sh_nxt = {r_rx_sh[6:0], MISO};
                    end
                    w_state_nxt = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (w_phase_end) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bit != 3'd7) begin
                        // MOSI is the shift register MSB, so shifting advances the line
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_sh_nxt = {r_tx_sh[6:0], 1'b0};
                        w_state_nxt = S_SHIFT_LO;
                    end else if (r_pad) begin
                        w_state_nxt = S_TAIL;
                    end else begin
                        w_rx_data_nxt  = r_rx_sh;
                        w_rx_valid_nxt = 1'b1;
                        w_remain_nxt   = r_remain - LEN_W'(1);
                        if (r_remain != LEN_W'(1)) begin
                            w_state_nxt = S_LOAD;
                        end else if (c_PAD_EN) begin
                            // Two zero bits: start the bit counter at 6
                            w_pad_nxt   = 1'b1;
                            w_bit_nxt   = 3'd6;
                            w_tx_sh_nxt = 8'h00;
                            w_state_nxt = S_SHIFT_LO;
                        end else begin
                            w_state_nxt = S_TAIL;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (w_phase_end) begin
                    w_ss_nxt    = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_phase_end) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_tx_sh_nxt = 8'h00;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_ready = (r_state == S_LOAD);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign SCLK     = r_sclk;
    assign MOSI     = r_tx_sh[7];
    assign SS       = r_ss;

endmodule

`default_nettype wire

// File: tb/tb_spi_config_master.sv
// ============================================================================
// Module      : tb_spi_config_master
// Description : Self-checking bench for spi_config_master with an SPI bus
//               monitor, MISO slave model and frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_config_master;

    localparam int LEN_W = 9;
    localparam int DIV_W = 8;
`ifdef SPI_MOSI_PAD_EN
    localparam int PAD_BITS = 2;
`else
    localparam int PAD_BITS = 0;
`endif

    logic             system_clock = 1'b0;
    logic             reset        = 1'b1;
    logic             start        = 1'b0;
    logic [LEN_W-1:0] frame_bytes  = '0;
    logic [DIV_W-1:0] sclk_div     = '0;
    logic [7:0]       tx_data      = 8'h00;
    logic             tx_valid     = 1'b0;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             SCLK;
    logic             MOSI;
    logic             SS;
    logic             MISO = 1'b0;

    spi_config_master #(.LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .start        (start),
        .frame_bytes  (frame_bytes),
        .sclk_div     (sclk_div),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .busy         (busy),
        .done         (done),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .SS           (SS),
        .MISO         (MISO)
    );

    always #5 system_clock = ~system_clock;

    int compared   = 0;
    int mismatched = 0;

    // Stimulus/model settings written by the test sequence only
    logic       mon_clr = 1'b0;
    int         exp_h   = 1;
    int         miso_n  = 0;
    logic [7:0] miso_src [0:7];
    logic [7:0] tx_bytes [0:7];
    int         stall_q  [0:7];

    // Bus observations written by the monitor only
    int         pulses, ss_viol, hi_viol, setup_viol, done_cnt, busy_seen;
    int         cyc = 0, last_fall_cyc, ss_rise_cyc, done_cyc, stab, miso_idx, hi_cnt;
    logic       mosi_bits [$];
    int         hi_len_q  [$];
    logic [7:0] rx_got    [$];
    logic       prev_sclk = 1'b0, prev_ss = 1'b1, prev_mosi = 1'b0;

    function automatic logic miso_bit(input int idx);
        logic [7:0] b;
        if (idx >= miso_n * 8) return 1'b0;
        b = miso_src[idx / 8];
        return b[7 - (idx % 8)];
    endfunction

    always @(negedge system_clock) begin
        cyc = cyc + 1;
        if (mon_clr) begin
            pulses = 0; ss_viol = 0; hi_viol = 0; setup_viol = 0;
            done_cnt = 0; busy_seen = 0; last_fall_cyc = 0; ss_rise_cyc = 0;
            done_cyc = 0; stab = 0; miso_idx = 0; hi_cnt = 0; MISO = 1'b0;
            mosi_bits.delete(); hi_len_q.delete(); rx_got.delete();
        end else begin
            if (SCLK && !prev_sclk) begin
                pulses = pulses + 1;
                mosi_bits.push_back(MOSI);
                if (SS !== 1'b0) ss_viol = ss_viol + 1;
                if (stab < exp_h) setup_viol = setup_viol + 1;
                hi_cnt = 1;
            end else if (SCLK) begin
                hi_cnt = hi_cnt + 1;
                if (MOSI !== prev_mosi) hi_viol = hi_viol + 1;
            end
            if (!SCLK && prev_sclk) begin
                hi_len_q.push_back(hi_cnt);
                last_fall_cyc = cyc;
                MISO = miso_bit(miso_idx);
                miso_idx = miso_idx + 1;
            end
            if (!SS && prev_ss) begin
                MISO = miso_bit(miso_idx);
                miso_idx = miso_idx + 1;
            end
            if (SS && !prev_ss) ss_rise_cyc = cyc;
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (busy) busy_seen = busy_seen + 1;
            if (rx_valid) rx_got.push_back(rx_data);
        end
        stab = (MOSI !== prev_mosi) ? 1 : stab + 1;
        prev_sclk = SCLK;
        prev_ss   = SS;
        prev_mosi = MOSI;
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge system_clock);
        #1 mon_clr = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output bit ok);
        int k = 0;
        @(negedge system_clock);
        while (!tx_ready && k < 4000) begin
            @(negedge system_clock);
            k++;
        end
        ok = tx_ready;
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: tx_ready timeout got 0 want 1", tag);
        end
    endtask

    // Drives one complete frame and checks it against the frame-level model
    task automatic run_frame(input string tag, input int n, input int div);
        bit         ok;
        int         k, bad;
        logic       exp_bits [$];
        logic [7:0] b;
        clear_mon();
        exp_h  = div + 1;
        miso_n = n;
        @(posedge system_clock); #1;
        start = 1'b1; frame_bytes = n[LEN_W-1:0]; sclk_div = div[DIV_W-1:0];
        @(posedge system_clock); #1;
        start = 1'b0;
        frame_bytes = LEN_W'($urandom_range(1, 7));
        sclk_div    = DIV_W'($urandom_range(0, 7));
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL %s: busy after start got %b want 1", tag, busy);
        end
        for (int i = 0; i < n; i++) begin
            wait_ready(tag, ok);
            if (!ok) return;
            for (int s = 0; s < stall_q[i]; s++) begin
                compared++;
                if ({SCLK, SS, tx_ready} !== 3'b001) begin
                    mismatched++;
                    $display("FAIL %s: stall SCLK/SS/ready got %b want 001", tag, {SCLK, SS, tx_ready});
                end
                @(negedge system_clock);
            end
            tx_data  = tx_bytes[i];
            tx_valid = 1'b1;
            @(posedge system_clock); #1;
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            if (i == 0) begin
                start = 1'b1; frame_bytes = LEN_W'(1); sclk_div = '0;
                @(posedge system_clock); #1;
                start = 1'b0;
            end
        end
        k = 0;
        while (done_cnt == 0 && k < 20000) begin
            @(negedge system_clock);
            k++;
        end
        repeat (4) @(negedge system_clock);

        foreach (tx_bytes[i]) begin
            if (i < n) begin
                b = tx_bytes[i];
                for (int j = 7; j >= 0; j--) exp_bits.push_back(b[j]);
            end
        end
        for (int p = 0; p < PAD_BITS; p++) exp_bits.push_back(1'b0);

        compared++;
        if (pulses != exp_bits.size()) begin
            mismatched++;
            $display("FAIL %s: SCLK pulses got %0d want %0d", tag, pulses, exp_bits.size());
        end
        bad = 0;
        foreach (exp_bits[i]) if (i >= mosi_bits.size() || mosi_bits[i] !== exp_bits[i]) bad++;
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL %s: MOSI bits wrong got %0d bad want 0", tag, bad);
        end
        bad = 0;
        foreach (hi_len_q[i]) if (hi_len_q[i] != exp_h) bad++;
        compared++;
        if (bad != 0 || hi_len_q.size() == 0) begin
            mismatched++;
            $display("FAIL %s: high phases wrong got %0d bad want 0 (H=%0d)", tag, bad, exp_h);
        end
        compared++;
        if (ss_viol != 0 || hi_viol != 0 || setup_viol != 0) begin
            mismatched++;
            $display("FAIL %s: bus violations ss/hi/setup got %0d/%0d/%0d want 0/0/0",
                     tag, ss_viol, hi_viol, setup_viol);
        end
        compared++;
        if (done_cnt != 1) begin
            mismatched++;
            $display("FAIL %s: done pulses got %0d want 1", tag, done_cnt);
        end
        compared++;
        if (rx_got.size() != n) begin
            mismatched++;
            $display("FAIL %s: rx_valid pulses got %0d want %0d", tag, rx_got.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                compared++;
                if (rx_got[i] !== miso_src[i]) begin
                    mismatched++;
                    $display("FAIL %s: rx_data[%0d] got %h want %h", tag, i, rx_got[i], miso_src[i]);
                end
            end
        end
        compared++;
        if ((ss_rise_cyc - last_fall_cyc) != exp_h || (done_cyc - ss_rise_cyc) != exp_h) begin
            mismatched++;
            $display("FAIL %s: tail/gap cycles got %0d/%0d want %0d/%0d", tag,
                     ss_rise_cyc - last_fall_cyc, done_cyc - ss_rise_cyc, exp_h, exp_h);
        end
        compared++;
        if ({busy, SS, SCLK, MOSI} !== 4'b0100) begin
            mismatched++;
            $display("FAIL %s: idle busy/SS/SCLK/MOSI got %b want 0100", tag, {busy, SS, SCLK, MOSI});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge system_clock);
        #1;
        compared++;
        if ({SCLK, SS, MOSI, tx_ready, rx_data, rx_valid, busy, done} !== {4'b0100, 8'h00, 3'b000}) begin
            mismatched++;
            $display("FAIL reset: outputs got %b want %b",
                     {SCLK, SS, MOSI, tx_ready, rx_data, rx_valid, busy, done}, {4'b0100, 8'h00, 3'b000});
        end
        reset = 1'b0;
    endtask

    task automatic clear_stalls();
        foreach (stall_q[i]) stall_q[i] = 0;
    endtask

    task automatic test_single_byte();
        clear_stalls();
        tx_bytes[0] = 8'hA5;
        miso_src[0] = 8'h3C;
        run_frame("single_byte", 1, 0);
    endtask

    task automatic test_stall();
        clear_stalls();
        stall_q[1] = 20;
        tx_bytes[0] = 8'h81; tx_bytes[1] = 8'h7E;
        miso_src[0] = 8'hC3; miso_src[1] = 8'h5A;
        run_frame("stall", 2, 3);
    endtask

    task automatic test_zero_len();
        clear_mon();
        @(posedge system_clock); #1;
        start = 1'b1; frame_bytes = '0; sclk_div = DIV_W'(2);
        @(posedge system_clock); #1;
        start = 1'b0;
        repeat (20) @(negedge system_clock);
        compared++;
        if (busy_seen != 0 || done_cnt != 0 || SS !== 1'b1) begin
            mismatched++;
            $display("FAIL zero_len: busy cycles/done/SS got %0d/%0d/%b want 0/0/1", busy_seen, done_cnt, SS);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        clear_stalls();
        clear_mon();
        miso_n = 2;
        @(posedge system_clock); #1;
        start = 1'b1; frame_bytes = LEN_W'(2); sclk_div = DIV_W'(1);
        @(posedge system_clock); #1;
        start = 1'b0;
        wait_ready("reset_mid", ok);
        if (!ok) return;
        tx_data = 8'hF0; tx_valid = 1'b1;
        @(posedge system_clock); #1;
        tx_valid = 1'b0;
        while (pulses < 3 && k < 2000) begin
            @(negedge system_clock);
            k++;
        end
        reset = 1'b1;
        @(posedge system_clock); #1;
        compared++;
        if ({SS, SCLK, MOSI, busy, tx_ready, done} !== 6'b100000) begin
            mismatched++;
            $display("FAIL reset_mid: SS/SCLK/MOSI/busy/ready/done got %b want 100000",
                     {SS, SCLK, MOSI, busy, tx_ready, done});
        end
        reset = 1'b0;
        repeat (40) @(negedge system_clock);
        compared++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: done pulses/busy got %0d/%b want 0/0", done_cnt, busy);
        end
        tx_bytes[0] = 8'h3D; tx_bytes[1] = 8'hE2;
        miso_src[0] = 8'h96; miso_src[1] = 8'h0F;
        run_frame("after_reset", 2, 1);
    endtask

    task automatic test_random();
        int n, div;
        for (int f = 0; f < 4; f++) begin
            n   = $urandom_range(1, 4);
            div = $urandom_range(0, 3);
            foreach (tx_bytes[i]) begin
                tx_bytes[i] = 8'($urandom);
                miso_src[i] = 8'($urandom);
                stall_q[i]  = $urandom_range(0, 5);
            end
            run_frame("random", n, div);
        end
    endtask

    initial begin
        foreach (tx_bytes[i]) begin
            tx_bytes[i] = 8'h00;
            miso_src[i] = 8'h00;
            stall_q[i]  = 0;
        end
        test_reset();
        test_single_byte();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
